// File: rtl/cpu_pkg.sv
// Shared widths and the reorder-buffer entry payload for the out-of-order core.
package cpu_pkg;

  localparam int unsigned DEPTH  = 32;
  localparam int unsigned TAG_W  = 5;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = TAG_W + 1;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              has_dest;
    logic [REG_W-1:0]  dest_reg;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer; decides alloc and commit fires.
module rob_ptr_ctrl
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_alloc_valid,
  input  logic             i_head_done,
  output logic [TAG_W-1:0] o_head,
  output logic [TAG_W-1:0] o_tail,
  output logic [CNT_W-1:0] o_count,
  output logic             o_alloc_ready,
  output logic             o_alloc_fire,
  output logic             o_commit_fire
);

  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Full is judged on the registered count, so a commit never frees a slot in its own cycle.
  assign o_alloc_ready = (r_count != CNT_W'(DEPTH));
  assign o_alloc_fire  = i_alloc_valid && o_alloc_ready;
  assign o_commit_fire = i_head_done;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (o_alloc_fire)  r_tail <= r_tail + TAG_W'(1);
      if (o_commit_fire) r_head <= r_head + TAG_W'(1);
      case ({o_alloc_fire, o_commit_fire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_head;
  assign o_tail  = r_tail;
  assign o_count = r_count;

endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates tags, captures CDB results,
// serves rename operand lookups and retires in program order.
module reorder_buffer
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alloc_valid,
  input  logic              alloc_has_dest,
  input  logic [REG_W-1:0]  alloc_dest_reg,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic [TAG_W-1:0]  lookup_tag_a,
  input  logic [TAG_W-1:0]  lookup_tag_b,
  output logic              lookup_ready_a,
  output logic              lookup_ready_b,
  output logic [DATA_W-1:0] lookup_data_a,
  output logic [DATA_W-1:0] lookup_data_b,
  output logic              commit_valid,
  output logic              commit_has_dest,
  output logic [REG_W-1:0]  commit_dest_reg,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [CNT_W-1:0]  count
);

  rob_entry_t r_rob [DEPTH];

  logic [TAG_W-1:0] w_head;
  logic [TAG_W-1:0] w_tail;
  logic             w_alloc_fire;
  logic             w_commit_fire;
  logic             w_head_done;
  rob_entry_t       w_head_ent;
  rob_entry_t       w_ent_a;
  rob_entry_t       w_ent_b;
  logic             w_byp_a;
  logic             w_byp_b;

  assign w_head_ent  = r_rob[w_head];
  assign w_head_done = w_head_ent.busy && w_head_ent.done;

  rob_ptr_ctrl u_ptr (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (flush),
    .i_alloc_valid (alloc_valid),
    .i_head_done   (w_head_done),
    .o_head        (w_head),
    .o_tail        (w_tail),
    .o_count       (count),
    .o_alloc_ready (alloc_ready),
    .o_alloc_fire  (w_alloc_fire),
    .o_commit_fire (w_commit_fire)
  );

  assign alloc_tag = w_tail;

  // Entry array: writeback, then retire, then allocate (indices never collide when they fire).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rob[i] <= '0;
      end
    end else begin
      if (cdb_valid && r_rob[cdb_tag].busy) begin
        r_rob[cdb_tag].done <= 1'b1;
        r_rob[cdb_tag].data <= cdb_data;
      end
      if (w_commit_fire) begin
        r_rob[w_head].busy <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_rob[w_tail].busy     <= 1'b1;
        r_rob[w_tail].done     <= 1'b0;
        r_rob[w_tail].has_dest <= alloc_has_dest;
        r_rob[w_tail].dest_reg <= alloc_dest_reg;
      end
    end
  end

  // Retire port; fields are zeroed whenever nothing retires.
  assign commit_valid    = w_head_done;
  assign commit_has_dest = w_head_done && w_head_ent.has_dest;
  assign commit_dest_reg = w_head_done ? w_head_ent.dest_reg : '0;
  assign commit_data     = w_head_done ? w_head_ent.data : '0;
  assign commit_tag      = w_head_done ? w_head : '0;

  // Operand lookup with same-cycle CDB bypass for live entries.
  assign w_ent_a = r_rob[lookup_tag_a];
  assign w_ent_b = r_rob[lookup_tag_b];
  assign w_byp_a = cdb_valid && (cdb_tag == lookup_tag_a) && w_ent_a.busy;
  assign w_byp_b = cdb_valid && (cdb_tag == lookup_tag_b) && w_ent_b.busy;

  assign lookup_ready_a = (w_ent_a.busy && w_ent_a.done) || w_byp_a;
  assign lookup_ready_b = (w_ent_b.busy && w_ent_b.done) || w_byp_b;
  assign lookup_data_a  = w_byp_a ? cdb_data : w_ent_a.data;
  assign lookup_data_b  = w_byp_b ? cdb_data : w_ent_b.data;

endmodule
